global_result_drain: RTL and testbench
======================================

Name: global_result_drain

Overview:
Reads the output feature-map results that the PE array chain writes into the upper half of the global buffer, starting at SIZE_GLOBAL/2, and streams them to the host over a valid/ready interface. It is the read-side counterpart to the array's write-back path. It sits beside the global controller and shares the global buffer read port under a grant signal. It absorbs the buffer's 1-cycle read latency and host back-pressure with a 2-entry output FIFO.

Parameters:
DATA_WIDTH, 4, result data width streamed to the host
WORD_WIDTH, DATA_WIDTH+2, global buffer word width
KB, 32, global buffer capacity in KB
SIZE_GLOBAL, (KB*8192)/DATA_WIDTH, global buffer depth in words
ADDR_WIDTH_GLOBAL, $clog2(SIZE_GLOBAL), global buffer address width
BASE_ADDR, SIZE_GLOBAL/2, first result address

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  1-cycle pulse that begins a drain; ignored while busy
num_results  in  ADDR_WIDTH_GLOBAL  number of results to drain; sampled on start
gb_grant  in  1  the global buffer read port is available to this block this cycle
ren_global  out  1  global buffer read enable
r_addr  out  ADDR_WIDTH_GLOBAL  global buffer read address
dout_global  in  WORD_WIDTH  global buffer read data, valid 1 cycle after ren_global
m_data  out  DATA_WIDTH  result beat, equal to dout_global[DATA_WIDTH-1:0]
m_valid  out  1  m_data is valid
m_ready  in  1  host accepts the beat
m_last  out  1  marks the final beat of the drain
busy  out  1  a drain is in progress
done  out  1  1-cycle pulse when the drain completes

Behaviour:
- Reset values: ren_global=0, r_addr=BASE_ADDR, m_valid=0, m_last=0, m_data=0, busy=0, done=0. Reset also empties the FIFO and clears in-flight tracking.
- Reset mid-drain aborts the drain. Any return data from a read already in flight is discarded, and no done pulse is produced.
- States:
  - IDLE: busy=0.
    - start with num_results=0: done pulses on the next cycle; state stays IDLE.
    - start with num_results!=0: latch n = min(num_results, SIZE_GLOBAL/2), set issued=0, go to DRAIN.
  - DRAIN: busy=1.
    - ren_global = gb_grant && (fifo_count + inflight < 2) && (issued < n).
    - r_addr = BASE_ADDR + issued. On each issued read, issued increments.
    - When issued reaches n, go to FLUSH.
  - FLUSH: busy=1. Go to DONE once inflight=0, the FIFO is empty, and the last beat's handshake has occurred.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Read return: the cycle after ren_global, the word is pushed into the FIFO together with a last tag, set when it is read index n-1. dout_global[WORD_WIDTH-1:DATA_WIDTH] is discarded.
- Credit rule: the FIFO can never overflow, because reads are only issued against free slots counting in-flight reads.
- Output: m_valid = FIFO non-empty. m_data and m_last come from the FIFO head.
  - Pop on m_valid && m_ready.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - Push and pop in the same cycle is legal and leaves the occupancy unchanged.
- Latency and throughput: start at cycle 0; first ren_global at cycle 1 if granted; first m_valid at cycle 2. With gb_grant=1 and m_ready=1 the block sustains 1 beat per cycle.
- gb_grant low: no reads are issued; already in-flight data is still captured. Grant may toggle every cycle.
- Address bound: r_addr never exceeds SIZE_GLOBAL-1, guaranteed by the clamp on n.
- Simultaneous events:
  - start during DONE is ignored.
  - start in the same cycle as rst is ignored.
  - done and the last handshake never occur in the same cycle; done follows the last handshake by at least 1 cycle.

Decomposition:
- Shared package holds WORD_WIDTH, SIZE_GLOBAL, ADDR_WIDTH_GLOBAL, BASE_ADDR and the drain state encoding (IDLE, DRAIN, FLUSH, DONE).
- One sub-module is natural: drain_fifo, a 2-entry synchronous FIFO of width DATA_WIDTH+1 (data plus last tag) with push, pop, empty, full and count outputs, using the same clk/rst convention.
- Address and issued counters stay inline.

Test Plan:
- num_results=4, gb_grant=1, m_ready=1, buffer[BASE_ADDR..+3] = 6'h01,02,03,04 -> reads at cycles 1-4, beats 1,2,3,4 at cycles 2-5, m_last on the 4th beat, done at cycle 6.
- num_results=6, m_ready low on alternate cycles -> no more than 2 outstanding reads; data and order preserved; m_data stable while stalled; exactly 6 handshakes.
- num_results=5, gb_grant pulses 1 cycle in 3 -> reads only on grant cycles; r_addr = BASE_ADDR+k in order; 5 beats; done once.
- num_results=0 -> ren_global never asserts, no m_valid, done pulses 1 cycle after start.
- num_results=3, rst asserted on the cycle the 2nd read issues -> next cycle all outputs at reset values, no done; a following start with num_results=2 drains from BASE_ADDR correctly.
- num_results=SIZE_GLOBAL/2+10 -> clamped; last r_addr = SIZE_GLOBAL-1 with m_last set on that beat; start pulses while busy have no effect.

Source files
------------

// File: rtl/global_result_drain_pkg.sv
// Shared constants and drain state encoding for the global buffer result drain.
package global_result_drain_pkg;

  localparam int DATA_WIDTH        = 4;
  localparam int KB                = 32;
  localparam int WORD_WIDTH        = DATA_WIDTH + 2;
  localparam int SIZE_GLOBAL       = (KB * 8192) / DATA_WIDTH;
  localparam int ADDR_WIDTH_GLOBAL = $clog2(SIZE_GLOBAL);
  localparam int FIFO_WIDTH        = DATA_WIDTH + 1;

  // Results live in the upper half of the buffer, so at most half the depth can be drained.
  localparam logic [ADDR_WIDTH_GLOBAL-1:0] BASE_ADDR   = ADDR_WIDTH_GLOBAL'(SIZE_GLOBAL / 2);
  localparam logic [ADDR_WIDTH_GLOBAL-1:0] MAX_RESULTS = ADDR_WIDTH_GLOBAL'(SIZE_GLOBAL / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  // Limits a requested result count so reads never run past the top of the buffer.
  function automatic logic [ADDR_WIDTH_GLOBAL-1:0] clamp_results(
    input logic [ADDR_WIDTH_GLOBAL-1:0] req
  );
    return (req > MAX_RESULTS) ? MAX_RESULTS : req;
  endfunction

endpackage

// File: rtl/global_result_drain_fifo.sv
// Two-entry synchronous FIFO holding result beats (data plus last tag); entry 0 is always the head.
module drain_fifo #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;

  // Next-state for the two slots: a pop shifts entry 1 down, a push fills the first free slot.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          slot1_d = push_data;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q != 2'd0) begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
      end
      2'b11: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign count = count_q;

endmodule

// File: rtl/global_result_drain.sv
// Streams results from the upper half of the global buffer to the host over valid/ready.
// The word returning from an in-flight read is presented directly when the FIFO is empty,
// so a granted, unstalled drain produces one beat per cycle with one cycle of read latency.
module global_result_drain
  import global_result_drain_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH_GLOBAL-1:0] num_results,
  input  logic                         gb_grant,
  output logic                         ren_global,
  output logic [ADDR_WIDTH_GLOBAL-1:0] r_addr,
  input  logic [WORD_WIDTH-1:0]        dout_global,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done
);

  drain_state_e                   state_q, state_d;
  logic [ADDR_WIDTH_GLOBAL-1:0]   n_q, n_d;
  logic [ADDR_WIDTH_GLOBAL-1:0]   issued_q, issued_d;
  logic                           inflight_q, inflight_d;
  logic                           inflight_last_q, inflight_last_d;
  logic                           zero_done_q, zero_done_d;

  logic                           fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [1:0]                     fifo_count;
  logic [FIFO_WIDTH-1:0]          fifo_head, head_sel, return_beat;
  logic [2:0]                     occupancy;
  logic                           out_valid, handshake, last_handshake;
  logic                           unused_tag_bits;

  assign unused_tag_bits = ^{dout_global[WORD_WIDTH-1:DATA_WIDTH], fifo_full};
  assign return_beat     = {inflight_last_q, dout_global[DATA_WIDTH-1:0]};
  assign occupancy       = {1'b0, fifo_count} + {2'b00, inflight_q};

  drain_fifo #(
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (return_beat),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Output side: FIFO head if present, otherwise the returning word bypasses the FIFO.
  always_comb begin
    out_valid      = !fifo_empty || inflight_q;
    head_sel       = fifo_empty ? return_beat : fifo_head;
    handshake      = out_valid && m_ready;
    last_handshake = handshake && head_sel[DATA_WIDTH];
    fifo_pop       = handshake && !fifo_empty;
    fifo_push      = inflight_q && !(handshake && fifo_empty);
    m_valid        = out_valid;
    m_data         = out_valid ? head_sel[DATA_WIDTH-1:0] : '0;
    m_last         = out_valid && head_sel[DATA_WIDTH];
  end

  // Drain sequencing: read issue against free credits, address generation and completion.
  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    issued_d        = issued_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    zero_done_d     = 1'b0;
    ren_global      = 1'b0;
    r_addr          = BASE_ADDR;
    busy            = 1'b0;
    done            = zero_done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_results == '0) begin
            zero_done_d = 1'b1;
          end else begin
            n_d      = clamp_results(num_results);
            issued_d = '0;
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        r_addr     = BASE_ADDR + issued_q;
        ren_global = gb_grant && (occupancy < 3'd2) && (issued_q < n_q);
        if (ren_global) begin
          issued_d        = issued_q + ADDR_WIDTH_GLOBAL'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (issued_q == n_q - ADDR_WIDTH_GLOBAL'(1));
          if (issued_q + ADDR_WIDTH_GLOBAL'(1) == n_q) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (last_handshake) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      n_q             <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      zero_done_q     <= zero_done_d;
    end
  end

endmodule

// File: tb/tb_global_result_drain.sv
// Randomised scenario bench for global_result_drain with a behavioural buffer and result model.
module tb_global_result_drain;
  import global_result_drain_pkg::*;

  localparam int HALF = SIZE_GLOBAL / 2;

  logic                         clk = 1'b0;
  logic                         rst, start, gb_grant, m_ready;
  logic [ADDR_WIDTH_GLOBAL-1:0] num_results, r_addr;
  logic                         ren_global, m_valid, m_last, busy, done;
  logic [WORD_WIDTH-1:0]        dout_global;
  logic [DATA_WIDTH-1:0]        m_data;

  int checks   = 0;
  int failures = 0;

  logic [WORD_WIDTH-1:0] gb_mem [0:SIZE_GLOBAL-1];

  int                           ren_cyc[$];
  int                           beat_cyc[$];
  logic [ADDR_WIDTH_GLOBAL-1:0] obs_addr[$];
  logic [DATA_WIDTH-1:0]        obs_data[$];
  logic                         obs_last[$];
  int done_cnt, done_cyc, ren_no_grant, max_out, stall_viol, done_with_hs;
  int post_activity, busy_cnt, timed_out;

  global_result_drain dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_results (num_results),
    .gb_grant    (gb_grant),
    .ren_global  (ren_global),
    .r_addr      (r_addr),
    .dout_global (dout_global),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Global buffer model: one-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    if (ren_global === 1'b1) dout_global <= gb_mem[r_addr];
    else dout_global <= WORD_WIDTH'($urandom);
  end

  function automatic logic pick(input int mode, input int cyc, input int period);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc % period) == 1);
    return logic'($urandom_range(0, 1));
  endfunction

  // Index of the first beat that differs from the expected drain of n results, or -1.
  function automatic int seq_mismatch(input int n);
    for (int k = 0; k < n; k++) begin
      if (k >= obs_data.size() || k >= obs_addr.size()) return k;
      if (obs_data[k] !== gb_mem[int'(BASE_ADDR) + k][DATA_WIDTH-1:0]) return k;
      if (obs_last[k] !== (k == n - 1)) return k;
      if (obs_addr[k] !== ADDR_WIDTH_GLOBAL'(int'(BASE_ADDR) + k)) return k;
    end
    return -1;
  endfunction

  // Runs one drain: start at cycle 0, optional extra start pulses, records what the DUT does.
  task automatic run_drain(input int num, input int gmode, input int rmode,
                           input int s1, input int s2, input int budget);
    int cyc, issued_cnt, hs_cnt, post;
    bit prev_stall, hs;
    logic [DATA_WIDTH-1:0] prev_data;
    logic prev_last;
    ren_cyc.delete(); beat_cyc.delete(); obs_addr.delete(); obs_data.delete(); obs_last.delete();
    done_cnt = 0; done_cyc = -1; ren_no_grant = 0; max_out = 0; stall_viol = 0;
    done_with_hs = 0; post_activity = 0; busy_cnt = 0; timed_out = 0;
    issued_cnt = 0; hs_cnt = 0; post = -1; prev_stall = 0; prev_data = '0; prev_last = 0;
    @(posedge clk); #1;
    cyc = 0;
    start = 1'b1;
    num_results = ADDR_WIDTH_GLOBAL'(num);
    gb_grant = pick(gmode, cyc, 3);
    m_ready = pick(rmode, cyc, 2) | (rmode == 1 && cyc % 2 == 0);
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (post >= 0 && (ren_global || m_valid || busy)) post_activity++;
      if (ren_global) begin
        ren_cyc.push_back(cyc);
        obs_addr.push_back(r_addr);
        if (!gb_grant) ren_no_grant++;
        issued_cnt++;
      end
      if (issued_cnt - hs_cnt > max_out) max_out = issued_cnt - hs_cnt;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
      hs = m_valid && m_ready;
      if (hs) begin
        obs_data.push_back(m_data);
        obs_last.push_back(m_last);
        beat_cyc.push_back(cyc);
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (hs) done_with_hs++;
        if (post < 0) post = 0;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (post >= 0) post++;
      if (post >= 4) break;
      if (cyc >= budget) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == s1) || (cyc == s2);
      num_results = ADDR_WIDTH_GLOBAL'(3);
      gb_grant = pick(gmode, cyc, 3);
      m_ready = (rmode == 1) ? (cyc % 2 == 0) : pick(rmode, cyc, 2);
    end
    @(posedge clk); #1;
    start = 1'b0;
    gb_grant = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gb_grant = 1'b1; m_ready = 1'b1; num_results = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ren_global !== 1'b0) begin failures++; $display("[TB] FAIL reset_ren got=%b exp=0", ren_global); end
    checks++; if (r_addr !== BASE_ADDR) begin failures++; $display("[TB] FAIL reset_raddr got=%h exp=%h", r_addr, BASE_ADDR); end
    checks++; if ({m_valid, m_last, m_data} !== '0) begin failures++; $display("[TB] FAIL reset_stream got=%b%b%h exp=0", m_valid, m_last, m_data); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("[TB] FAIL reset_status got=%b%b exp=00", busy, done); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) gb_mem[int'(BASE_ADDR) + k] = WORD_WIDTH'(k + 1);
    run_drain(4, 0, 0, 6, -1, 200);
    checks++;
    if (ren_cyc.size() != 4 || ren_cyc[0] != 1 || ren_cyc[3] != 4)
      begin failures++; $display("[TB] FAIL basic_ren_cycles got=%p exp=1..4", ren_cyc); end
    checks++;
    if (beat_cyc.size() != 4 || beat_cyc[0] != 2 || beat_cyc[3] != 5)
      begin failures++; $display("[TB] FAIL basic_beat_cycles got=%p exp=2..5", beat_cyc); end
    checks++;
    if (seq_mismatch(4) != -1) begin failures++; $display("[TB] FAIL basic_beats got=%p last=%p exp=1,2,3,4", obs_data, obs_last); end
    checks++;
    if (done_cyc != 6 || done_cnt != 1) begin failures++; $display("[TB] FAIL basic_done got=cyc%0d/n%0d exp=cyc6/n1", done_cyc, done_cnt); end
    checks++;
    if (post_activity != 0) begin failures++; $display("[TB] FAIL start_in_done got=%0d active cycles exp=0", post_activity); end
  endtask

  task automatic test_backpressure();
    run_drain(6, 0, 1, -1, -1, 300);
    checks++;
    if (obs_data.size() != 6 || seq_mismatch(6) != -1) begin failures++; $display("[TB] FAIL bp_beats got=%0d beats idx%0d exp=6 in order", obs_data.size(), seq_mismatch(6)); end
    checks++;
    if (max_out > 2) begin failures++; $display("[TB] FAIL bp_outstanding got=%0d exp<=2", max_out); end
    checks++;
    if (stall_viol != 0) begin failures++; $display("[TB] FAIL bp_stable got=%0d changes exp=0", stall_viol); end
    checks++;
    if (done_cnt != 1 || done_with_hs != 0 || timed_out != 0) begin failures++; $display("[TB] FAIL bp_done got=n%0d hs%0d to%0d exp=n1 hs0 to0", done_cnt, done_with_hs, timed_out); end
  endtask

  task automatic test_sparse_grant();
    int bad;
    run_drain(5, 1, 0, -1, -1, 300);
    bad = 0;
    foreach (ren_cyc[i]) if (ren_cyc[i] % 3 != 1) bad++;
    checks++;
    if (ren_cyc.size() != 5 || bad != 0 || ren_no_grant != 0) begin failures++; $display("[TB] FAIL grant_reads got=%p exp=5 reads on grant cycles", ren_cyc); end
    checks++;
    if (seq_mismatch(5) != -1 || obs_data.size() != 5) begin failures++; $display("[TB] FAIL grant_beats got=idx%0d size%0d exp=-1 size5", seq_mismatch(5), obs_data.size()); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL grant_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_zero();
    run_drain(0, 0, 0, -1, -1, 50);
    checks++;
    if (ren_cyc.size() != 0 || obs_data.size() != 0) begin failures++; $display("[TB] FAIL zero_activity got=reads%0d beats%0d exp=0", ren_cyc.size(), obs_data.size()); end
    checks++;
    if (done_cyc != 1 || done_cnt != 1 || busy_cnt != 0) begin failures++; $display("[TB] FAIL zero_done got=cyc%0d n%0d busy%0d exp=cyc1 n1 busy0", done_cyc, done_cnt, busy_cnt); end
  endtask

  task automatic test_reset_abort();
    int act;
    @(posedge clk); #1;
    start = 1'b1; num_results = ADDR_WIDTH_GLOBAL'(3); gb_grant = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; num_results = ADDR_WIDTH_GLOBAL'(7);
    @(negedge clk);
    checks++;
    if (ren_global !== 1'b1 || r_addr !== BASE_ADDR + ADDR_WIDTH_GLOBAL'(1)) begin failures++; $display("[TB] FAIL abort_second_read got=%b/%h exp=1/%h", ren_global, r_addr, BASE_ADDR + ADDR_WIDTH_GLOBAL'(1)); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({ren_global, m_valid, m_last, m_data, busy, done} !== '0 || r_addr !== BASE_ADDR) begin failures++; $display("[TB] FAIL abort_outputs got=ren%b v%b l%b d%h b%b dn%b a%h exp=reset values", ren_global, m_valid, m_last, m_data, busy, done, r_addr); end
    act = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (ren_global || m_valid || busy || done) act++;
    end
    checks++;
    if (act != 0) begin failures++; $display("[TB] FAIL abort_quiet got=%0d active cycles exp=0", act); end
    run_drain(2, 0, 0, -1, -1, 100);
    checks++;
    if (obs_data.size() != 2 || seq_mismatch(2) != -1 || done_cnt != 1) begin failures++; $display("[TB] FAIL abort_restart got=size%0d idx%0d done%0d exp=2/-1/1", obs_data.size(), seq_mismatch(2), done_cnt); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 24);
      run_drain(n, 2, 2, -1, -1, 800);
      checks++;
      if (obs_data.size() != n || seq_mismatch(n) != -1) begin failures++; $display("[TB] FAIL rand_beats it%0d got=size%0d idx%0d exp=size%0d", it, obs_data.size(), seq_mismatch(n), n); end
      checks++;
      if (max_out > 2 || ren_no_grant != 0 || stall_viol != 0) begin failures++; $display("[TB] FAIL rand_rules it%0d got=out%0d ng%0d st%0d exp<=2/0/0", it, max_out, ren_no_grant, stall_viol); end
      checks++;
      if (done_cnt != 1 || done_with_hs != 0 || timed_out != 0) begin failures++; $display("[TB] FAIL rand_done it%0d got=n%0d hs%0d to%0d exp=1/0/0", it, done_cnt, done_with_hs, timed_out); end
    end
  endtask

  task automatic test_clamp();
    run_drain(HALF + 10, 0, 0, 5, 1000, 40000);
    checks++;
    if (obs_data.size() != HALF || seq_mismatch(HALF) != -1) begin failures++; $display("[TB] FAIL clamp_beats got=size%0d idx%0d exp=size%0d", obs_data.size(), seq_mismatch(HALF), HALF); end
    checks++;
    if (obs_addr.size() == 0 || obs_addr[obs_addr.size()-1] !== ADDR_WIDTH_GLOBAL'(SIZE_GLOBAL - 1)) begin failures++; $display("[TB] FAIL clamp_last_addr got=size%0d exp=last %h", obs_addr.size(), SIZE_GLOBAL - 1); end
    checks++;
    if (done_cnt != 1 || timed_out != 0 || post_activity != 0) begin failures++; $display("[TB] FAIL clamp_done got=n%0d to%0d post%0d exp=1/0/0", done_cnt, timed_out, post_activity); end
  endtask

  initial begin
    for (int a = 0; a < SIZE_GLOBAL; a++) gb_mem[a] = WORD_WIDTH'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_sparse_grant();
    test_zero();
    test_reset_abort();
    test_random();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
